// File: rtl/wbs_ctrl_slave.sv
// wbs_ctrl_slave: Wishbone slave exposing control CSRs and write/read
// windows into the node, leaf, query and best memories of a search engine.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   wbs_*                    Wishbone slave (cyc/stb/we/sel/adr/dat, ack/dat)
//   mode_o, debug_o          CSR bits
//   fsm_start_o              start pulse; fsm_done_i / fsm_busy_i status
//   node_*/leaf_*/query_*    registered memory write strobes, address, data
//   best_ren_o/best_raddr_o  best-array read; best_rdata_i valid next cycle
//   err_o                    sticky unmapped-access flag
//
// Optional feature macro: WBS_UNMAPPED_ACK_EN
//   defined   -> unmapped accesses are acked with data 0 and set err_o
//   undefined -> unmapped accesses get no ack, err_o is tied 0

module wbs_ctrl_slave #(
    parameter int DATA_WIDTH   = 11,
    parameter int NODE_ADDR_W  = 6,
    parameter int LEAF_ADDR_W  = 12,
    parameter int QUERY_ADDR_W = 12,
    parameter int BEST_ADDR_W  = 10
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic                      mode_o,
    output logic                      debug_o,
    output logic                      fsm_start_o,
    input  logic                      fsm_done_i,
    input  logic                      fsm_busy_i,
    output logic                      node_wen_o,
    output logic [NODE_ADDR_W-1:0]    node_waddr_o,
    output logic [2*DATA_WIDTH-1:0]   node_wdata_o,
    output logic                      leaf_wen_o,
    output logic [LEAF_ADDR_W-1:0]    leaf_waddr_o,
    output logic [63:0]               leaf_wdata_o,
    output logic                      query_wen_o,
    output logic [QUERY_ADDR_W-1:0]   query_waddr_o,
    output logic [5*DATA_WIDTH-1:0]   query_wdata_o,
    output logic                      best_ren_o,
    output logic [BEST_ADDR_W-1:0]    best_raddr_o,
    input  logic [31:0]               best_rdata_i,
    output logic                      err_o
);

    localparam logic [15:0] RG_CSR   = 16'h3000;
    localparam logic [15:0] RG_QUERY = 16'h3001;
    localparam logic [15:0] RG_LEAF  = 16'h3002;
    localparam logic [15:0] RG_BEST  = 16'h3003;
    localparam logic [15:0] RG_NODE  = 16'h3004;

    typedef enum logic {
        S_IDLE,
        S_BEST
    } state_t;

    state_t                    r_state;
    logic                      r_ack;
    logic [31:0]               r_dat;
    logic                      r_best_sel;
    logic                      r_mode;
    logic                      r_debug;
    logic                      r_start;
    logic                      r_node_wen;
    logic [NODE_ADDR_W-1:0]    r_node_waddr;
    logic [2*DATA_WIDTH-1:0]   r_node_wdata;
    logic                      r_leaf_wen;
    logic [LEAF_ADDR_W-1:0]    r_leaf_waddr;
    logic [63:0]               r_leaf_wdata;
    logic [31:0]               r_leaf_hold;
    logic                      r_query_wen;
    logic [QUERY_ADDR_W-1:0]   r_query_waddr;
    logic [5*DATA_WIDTH-1:0]   r_query_wdata;
    logic [31:0]               r_query_hold;
    logic                      r_best_ren;
    logic [BEST_ADDR_W-1:0]    r_best_raddr;
`ifdef WBS_UNMAPPED_ACK_EN
    logic                      r_err;
`endif

    logic [15:0] w_rg;
    logic [15:0] w_off;
    logic        w_acc;
    logic        w_wr;
    logic        w_csr;
    logic        w_mode;
    logic        w_debug;
    logic        w_done;
    logic        w_start;
    logic        w_busy;
    logic        w_query;
    logic        w_leaf;
    logic        w_best;
    logic        w_node;
    logic        w_mapped;
    logic        w_best_rd;
    logic [31:0] w_csr_rdata;

    assign w_rg  = wbs_adr_i[31:16];
    assign w_off = wbs_adr_i[15:0];

    // No new accept while acking or while a BEST read is in flight.
    assign w_acc = wbs_cyc_i & wbs_stb_i & ~r_ack & (r_state == S_IDLE);
    assign w_wr  = wbs_we_i & (wbs_sel_i == 4'hF);

    assign w_csr   = (w_rg == RG_CSR);
    assign w_mode  = w_csr & (w_off == 16'h0000);
    assign w_debug = w_csr & (w_off == 16'h0004);
    assign w_done  = w_csr & (w_off == 16'h0008);
    assign w_start = w_csr & (w_off == 16'h000C);
    assign w_busy  = w_csr & (w_off == 16'h0010);
    assign w_query = (w_rg == RG_QUERY);
    assign w_leaf  = (w_rg == RG_LEAF);
    assign w_best  = (w_rg == RG_BEST);
    assign w_node  = (w_rg == RG_NODE);

    assign w_mapped = w_mode | w_debug | w_done | w_start | w_busy |
                      w_query | w_leaf | w_best | w_node;

    assign w_best_rd = w_best & ~wbs_we_i;

    // Only CSR reads return non-zero data through the registered path.
    assign w_csr_rdata = {31'b0, (w_mode  & r_mode)     |
                                 (w_debug & r_debug)    |
                                 (w_done  & fsm_done_i) |
                                 (w_busy  & fsm_busy_i)};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= S_IDLE;
            r_ack         <= 1'b0;
            r_dat         <= '0;
            r_best_sel    <= 1'b0;
            r_mode        <= 1'b0;
            r_debug       <= 1'b0;
            r_start       <= 1'b0;
            r_node_wen    <= 1'b0;
            r_node_waddr  <= '0;
            r_node_wdata  <= '0;
            r_leaf_wen    <= 1'b0;
            r_leaf_waddr  <= '0;
            r_leaf_wdata  <= '0;
            r_leaf_hold   <= '0;
            r_query_wen   <= 1'b0;
            r_query_waddr <= '0;
            r_query_wdata <= '0;
            r_query_hold  <= '0;
            r_best_ren    <= 1'b0;
            r_best_raddr  <= '0;
`ifdef WBS_UNMAPPED_ACK_EN
            r_err         <= 1'b0;
`endif
        end else begin
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_best_sel  <= 1'b0;
            r_start     <= 1'b0;
            r_node_wen  <= 1'b0;
            r_leaf_wen  <= 1'b0;
            r_query_wen <= 1'b0;
            r_best_ren  <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        if (w_best_rd) begin
                            r_best_ren   <= 1'b1;
                            r_best_raddr <= wbs_adr_i[BEST_ADDR_W+1:2];
                            r_state      <= S_BEST;
                        end else if (w_mapped) begin
                            r_ack <= 1'b1;
                            if (!wbs_we_i) begin
                                r_dat <= w_csr_rdata;
                            end else if (w_wr) begin
                                if (w_mode && !fsm_busy_i)
                                    r_mode <= wbs_dat_i[0];
                                if (w_debug)
                                    r_debug <= wbs_dat_i[0];
                                if (w_start && !fsm_busy_i)
                                    r_start <= 1'b1;
                                if (w_node) begin
                                    r_node_wen   <= 1'b1;
                                    r_node_waddr <=
                                        wbs_adr_i[NODE_ADDR_W-1:0];
                                    r_node_wdata <=
                                        (2*DATA_WIDTH)'(wbs_dat_i);
                                end
                                if (w_leaf) begin
                                    if (wbs_adr_i[2]) begin
                                        r_leaf_wen   <= 1'b1;
                                        r_leaf_waddr <=
                                            wbs_adr_i[LEAF_ADDR_W+2:3];
                                        r_leaf_wdata <=
                                            {wbs_dat_i, r_leaf_hold};
                                    end else begin
                                        r_leaf_hold <= wbs_dat_i;
                                    end
                                end
                                if (w_query) begin
                                    if (wbs_adr_i[2]) begin
                                        r_query_wen   <= 1'b1;
                                        r_query_waddr <=
                                            wbs_adr_i[QUERY_ADDR_W+2:3];
                                        r_query_wdata <=
                                            (5*DATA_WIDTH)'(
                                            {wbs_dat_i, r_query_hold});
                                    end else begin
                                        r_query_hold <= wbs_dat_i;
                                    end
                                end
                            end
                        end else begin
`ifdef WBS_UNMAPPED_ACK_EN
                            r_ack <= 1'b1;
                            r_err <= 1'b1;
`endif
                        end
                    end
                end
                S_BEST: begin
                    // best_rdata_i is valid now; it is steered onto
                    // wbs_dat_o combinationally during the ack cycle.
                    r_ack      <= 1'b1;
                    r_best_sel <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wbs_ack_o     = r_ack;
    assign wbs_dat_o     = r_best_sel ? best_rdata_i : r_dat;
    assign mode_o        = r_mode;
    assign debug_o       = r_debug;
    assign fsm_start_o   = r_start;
    assign node_wen_o    = r_node_wen;
    assign node_waddr_o  = r_node_waddr;
    assign node_wdata_o  = r_node_wdata;
    assign leaf_wen_o    = r_leaf_wen;
    assign leaf_waddr_o  = r_leaf_waddr;
    assign leaf_wdata_o  = r_leaf_wdata;
    assign query_wen_o   = r_query_wen;
    assign query_waddr_o = r_query_waddr;
    assign query_wdata_o = r_query_wdata;
    assign best_ren_o    = r_best_ren;
    assign best_raddr_o  = r_best_raddr;
`ifdef WBS_UNMAPPED_ACK_EN
    assign err_o         = r_err;
`else
    assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_wbs_ctrl_slave.sv
// tb_wbs_ctrl_slave: table-driven bench for wbs_ctrl_slave plus
// hand-written sequences for back-to-back, split writes, reset and unmapped.

module tb_wbs_ctrl_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        mode, debug, start;
    logic        done = 1'b0;
    logic        busy = 1'b0;
    logic        node_wen;
    logic [5:0]  node_waddr;
    logic [21:0] node_wdata;
    logic        leaf_wen;
    logic [11:0] leaf_waddr;
    logic [63:0] leaf_wdata;
    logic        query_wen;
    logic [11:0] query_waddr;
    logic [54:0] query_wdata;
    logic        best_ren;
    logic [9:0]  best_raddr;
    logic [31:0] best_rdata = '0;
    logic        err;

    wbs_ctrl_slave dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .mode_o(mode), .debug_o(debug), .fsm_start_o(start),
        .fsm_done_i(done), .fsm_busy_i(busy),
        .node_wen_o(node_wen), .node_waddr_o(node_waddr),
        .node_wdata_o(node_wdata),
        .leaf_wen_o(leaf_wen), .leaf_waddr_o(leaf_waddr),
        .leaf_wdata_o(leaf_wdata),
        .query_wen_o(query_wen), .query_waddr_o(query_waddr),
        .query_wdata_o(query_wdata),
        .best_ren_o(best_ren), .best_raddr_o(best_raddr),
        .best_rdata_i(best_rdata), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        busy;
        logic        done;
        logic [31:0] brd;
        int          lat;
        logic [31:0] rdata;
        logic [4:0]  mask;
        logic        mode;
        logic        debug;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    int c_start, c_node, c_leaf, c_query, c_best, c_ack;
    logic [5:0]  cap_node_a;
    logic [21:0] cap_node_d;
    logic [11:0] cap_leaf_a;
    logic [63:0] cap_leaf_d;
    logic [11:0] cap_query_a;
    logic [54:0] cap_query_d;
    logic [9:0]  cap_best_a;

    function automatic vec_t mk(
        logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
        logic b, logic dn, logic [31:0] br, int l, logic [31:0] rd,
        logic [4:0] m, logic md, logic dg);
        vec_t v;
        v.we = w; v.adr = a; v.dat = d; v.sel = s; v.busy = b;
        v.done = dn; v.brd = br; v.lat = l; v.rdata = rd;
        v.mask = m; v.mode = md; v.debug = dg;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc = 1'b0;
        stb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one transaction, watch 4 cycles, drop stb on the ack.
    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output int lat, output logic [31:0] rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        lat = 0; rd = '0;
        c_start = 0; c_node = 0; c_leaf = 0; c_query = 0;
        c_best = 0; c_ack = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            if (start) c_start++;
            if (node_wen) begin
                c_node++; cap_node_a = node_waddr; cap_node_d = node_wdata;
            end
            if (leaf_wen) begin
                c_leaf++; cap_leaf_a = leaf_waddr; cap_leaf_d = leaf_wdata;
            end
            if (query_wen) begin
                c_query++; cap_query_a = query_waddr;
                cap_query_d = query_wdata;
            end
            if (best_ren) begin
                c_best++; cap_best_a = best_raddr;
            end
            if (ack) begin
                c_ack++;
                if (lat == 0) begin
                    lat = c; rd = rdat;
                    cyc = 1'b0; stb = 1'b0;
                end
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    logic [4:0] obs_mask;
    logic       multi;
    int         lat;
    logic [31:0] rd;
    logic       any_out;
    vec_t       vq[$];

    localparam logic [31:0] A_MODE  = 32'h3000_0000;
    localparam logic [31:0] A_DEBUG = 32'h3000_0004;
    localparam logic [31:0] A_DONE  = 32'h3000_0008;
    localparam logic [31:0] A_START = 32'h3000_000C;
    localparam logic [31:0] A_BUSY  = 32'h3000_0010;

`ifdef WBS_UNMAPPED_ACK_EN
    localparam int UNM_LAT = 1;
`else
    localparam int UNM_LAT = 0;
`endif

    initial begin
        // mask bits: [4] start [3] node [2] leaf [1] query [0] best
        vq.push_back(mk(1, A_DEBUG, 1, 4'hF, 0, 0, 0, 1, 0, 5'b00000, 0, 1));
        vq.push_back(mk(1, A_MODE, 1, 4'hF, 0, 0, 0, 1, 0, 5'b00000, 1, 1));
        vq.push_back(mk(0, A_MODE, 0, 4'hF, 0, 0, 0, 1, 1, 5'b00000, 1, 1));
        vq.push_back(mk(0, A_DEBUG, 0, 4'hF, 0, 0, 0, 1, 1, 5'b00000, 1, 1));
        vq.push_back(mk(0, A_DONE, 0, 4'hF, 0, 1, 0, 1, 1, 5'b00000, 1, 1));
        vq.push_back(mk(0, A_DONE, 0, 4'hF, 0, 0, 0, 1, 0, 5'b00000, 1, 1));
        vq.push_back(mk(0, A_BUSY, 0, 4'hF, 1, 0, 0, 1, 1, 5'b00000, 1, 1));
        vq.push_back(mk(0, A_START, 0, 4'hF, 0, 1, 0, 1, 0, 5'b00000, 1, 1));
        vq.push_back(mk(1, A_MODE, 0, 4'hF, 1, 0, 0, 1, 0, 5'b00000, 1, 1));
        vq.push_back(mk(1, A_MODE, 0, 4'h3, 0, 0, 0, 1, 0, 5'b00000, 1, 1));
        vq.push_back(mk(1, A_MODE, 0, 4'hF, 0, 0, 0, 1, 0, 5'b00000, 0, 1));
        vq.push_back(mk(1, A_START, 0, 4'hF, 0, 0, 0, 1, 0, 5'b10000, 0, 1));
        vq.push_back(mk(1, A_START, 1, 4'hF, 1, 0, 0, 1, 0, 5'b00000, 0, 1));
        vq.push_back(mk(1, A_START, 1, 4'h7, 0, 0, 0, 1, 0, 5'b00000, 0, 1));
        vq.push_back(mk(1, 32'h3004_0001, 7, 4'hF, 0, 0, 0, 1, 0,
                        5'b01000, 0, 1));
        vq.push_back(mk(1, 32'h3002_0000, 9, 4'hF, 0, 0, 0, 1, 0,
                        5'b00000, 0, 1));
        vq.push_back(mk(1, 32'h3001_0004, 3, 4'hF, 0, 0, 0, 1, 0,
                        5'b00010, 0, 1));
        vq.push_back(mk(1, 32'h3001_0004, 3, 4'hE, 0, 0, 0, 1, 0,
                        5'b00000, 0, 1));
        vq.push_back(mk(0, 32'h3003_0008, 0, 4'hF, 0, 0, 32'h1A3, 2,
                        32'h1A3, 5'b00001, 0, 1));
        vq.push_back(mk(1, 32'h3003_0008, 5, 4'hF, 0, 0, 32'h55, 1, 0,
                        5'b00000, 0, 1));
        vq.push_back(mk(0, 32'h3002_0000, 0, 4'hF, 0, 0, 0, 1, 0,
                        5'b00000, 0, 1));
        vq.push_back(mk(0, 32'h3004_0000, 0, 4'hF, 0, 1, 0, 1, 0,
                        5'b00000, 0, 1));
        vq.push_back(mk(1, A_DEBUG, 0, 4'hF, 0, 0, 0, 1, 0, 5'b00000, 0, 0));
        vq.push_back(mk(0, 32'h3000_0014, 0, 4'hF, 0, 0, 0, UNM_LAT, 0,
                        5'b00000, 0, 0));

        do_reset();
        #1;
        any_out = ack | (|rdat) | mode | debug | start | node_wen |
                  (|node_waddr) | (|node_wdata) | leaf_wen | (|leaf_waddr) |
                  (|leaf_wdata) | query_wen | (|query_waddr) |
                  (|query_wdata) | best_ren | (|best_raddr) | err;
        chk("reset_outs", 64'(any_out), 0);

        foreach (vq[i]) begin
            busy = vq[i].busy;
            done = vq[i].done;
            best_rdata = vq[i].brd;
            xfer(vq[i].we, vq[i].adr, vq[i].dat, vq[i].sel, lat, rd);
            obs_mask = {c_start != 0, c_node != 0, c_leaf != 0,
                        c_query != 0, c_best != 0};
            multi = (c_start > 1) || (c_node > 1) || (c_leaf > 1) ||
                    (c_query > 1) || (c_best > 1) || (c_ack > 1);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vq[i].lat));
            chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vq[i].rdata));
            chk($sformatf("v%0d_strobes", i), 64'({multi, obs_mask}),
                64'({1'b0, vq[i].mask}));
            chk($sformatf("v%0d_mode", i), 64'(mode), 64'(vq[i].mode));
            chk($sformatf("v%0d_debug", i), 64'(debug), 64'(vq[i].debug));
        end
        busy = 0; done = 0;

        // Back-to-back with stb held: DEBUG then MODE.
        do_reset();
        cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = A_DEBUG; dat = 1;
        @(posedge clk); #1;
        chk("b2b_ack1", 64'(ack), 1);
        chk("b2b_debug", 64'(debug), 1);
        adr = A_MODE;
        @(posedge clk); #1;
        chk("b2b_gap", 64'(ack), 0);
        chk("b2b_mode_early", 64'(mode), 0);
        @(posedge clk); #1;
        chk("b2b_ack2", 64'(ack), 1);
        chk("b2b_mode", 64'(mode), 1);
        cyc = 0; stb = 0;
        @(posedge clk); #1;
        chk("b2b_ack_end", 64'(ack), 0);

        // NODE write with unaligned byte offset.
        xfer(1, 32'h3004_0005, 32'h0002_B801, 4'hF, lat, rd);
        chk("node_cnt", 64'(c_node), 1);
        chk("node_addr", 64'(cap_node_a), 5);
        chk("node_data", 64'(cap_node_d), 64'h02B801);

        // LEAF split write, then an upper-only write reusing the hold.
        xfer(1, 32'h3002_0010, 32'h1234_5678, 4'hF, lat, rd);
        chk("leaf_lo_cnt", 64'(c_leaf), 0);
        xfer(1, 32'h3002_0014, 32'h0000_ABCD, 4'hF, lat, rd);
        chk("leaf_hi_cnt", 64'(c_leaf), 1);
        chk("leaf_addr", 64'(cap_leaf_a), 2);
        chk("leaf_data", cap_leaf_d, 64'h0000_ABCD_1234_5678);
        xfer(1, 32'h3002_001C, 32'h0000_0001, 4'hF, lat, rd);
        chk("leaf2_addr", 64'(cap_leaf_a), 3);
        chk("leaf2_data", cap_leaf_d, 64'h0000_0001_1234_5678);

        // BEST read: address and data latency.
        best_rdata = 32'h0000_01A3;
        xfer(0, 32'h3003_0008, 0, 4'hF, lat, rd);
        chk("best_addr", 64'(cap_best_a), 2);
        chk("best_lat", 64'(lat), 2);
        chk("best_data", 64'(rd), 64'h1A3);

        // Reset while a BEST read is pending.
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h3003_0004;
        @(posedge clk); #1;
        chk("pend_ren", 64'(best_ren), 1);
        rst = 1; cyc = 0; stb = 0;
        @(posedge clk); #1;
        chk("pend_noack", 64'(ack), 0);
        rst = 0;
        any_out = ack | (|rdat) | mode | debug | start | node_wen |
                  (|node_waddr) | (|node_wdata) | leaf_wen | (|leaf_waddr) |
                  (|leaf_wdata) | query_wen | (|query_waddr) |
                  (|query_wdata) | best_ren | (|best_raddr) | err;
        chk("pend_rst_outs", 64'(any_out), 0);
        @(posedge clk); #1;
        chk("pend_noack2", 64'(ack), 0);

        // Upper halves right after reset use a cleared hold.
        xfer(1, 32'h3001_0004, 32'hFFFF_FFFF, 4'hF, lat, rd);
        chk("query_cnt", 64'(c_query), 1);
        chk("query_addr", 64'(cap_query_a), 0);
        chk("query_data", 64'(cap_query_d), 64'h7F_FFFF_0000_0000);
        xfer(1, 32'h3002_0004, 32'h0000_0042, 4'hF, lat, rd);
        chk("leaf_rst_data", cap_leaf_d, 64'h0000_0042_0000_0000);

        // Unmapped region access.
        xfer(0, 32'h3005_0000, 0, 4'hF, lat, rd);
        chk("unm_lat", 64'(lat), 64'(UNM_LAT));
        chk("unm_rdata", 64'(rd), 0);
        chk("unm_err", 64'(err), 64'(UNM_LAT));
        xfer(0, A_MODE, 0, 4'hF, lat, rd);
        chk("unm_err_sticky", 64'(err), 64'(UNM_LAT));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
